sram_arbiter: RTL
=================

# sram_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage ARM pipeline. It runs a fixed-latency SRAM access through a small state machine and returns a one-cycle ready pulse to the granted requester. While a data access is outstanding it drives `freeze` to stall the pipeline. It replaces the tied-off `freeze` in the processor top.

## Interface
Parameters:
- `SRAM_AW`, 18: SRAM word-address width.
- `WAIT_CYCLES`, 4: SRAM access cycles per transaction; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  instruction-fetch request; held until `if_ready`.
- `if_addr`  in  32  fetch byte address.
- `if_rdata`  out  32  fetched instruction (registered).
- `if_ready`  out  1  one-cycle completion pulse for IF.
- `mem_r_en`, `mem_w_en`  in  1 each  data read and write requests; mutually exclusive; held until `mem_ready`.
- `mem_addr`  in  32  data byte address.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data (registered).
- `mem_ready`  out  1  one-cycle completion pulse for MEM.
- `freeze`  out  1  pipeline stall.
- `sram_addr`  out  SRAM_AW  word address.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  read data.
- `sram_we_n`  out  1  write enable, active-low.
- `sram_oe_n`  out  1  output enable, active-low.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - If any request is pending, pick a winner and latch it.
  - Latched fields: grant (IF/MEM), op (read/write), `addr[SRAM_AW+1:2]`, wdata.
  - Load `wait_cnt = WAIT_CYCLES-1`, then go to ACCESS.
  - No pending request: stay in IDLE.
- **Arbitration:** a data request (`mem_r_en | mem_w_en`) beats `if_req` when both are pending. The data instruction is older.
- **ACCESS:**
  - `sram_addr` and `sram_wdata` are driven from the latched values.
  - Write: `sram_we_n = 0`, `sram_oe_n = 1`. Read: `sram_we_n = 1`, `sram_oe_n = 0`.
  - `wait_cnt` decrements each cycle.
  - When `wait_cnt == 0`: on a read, capture `sram_rdata` into `if_rdata` or `mem_rdata` (granted port only), then go to DONE.
- **DONE:**
  - `sram_we_n = sram_oe_n = 1`; address held.
  - Assert `if_ready` or `mem_ready` for the granted port, then go to IDLE.
- **Outside the access:** `sram_we_n` and `sram_oe_n` are 1 in IDLE and DONE.
- **Read data hold:** `if_rdata` and `mem_rdata` keep their value until the next read completes on the same port. A write leaves `mem_rdata` unchanged.
- **freeze:** `(mem_r_en | mem_w_en) & ~mem_ready`, combinational. IF waiting alone does not raise `freeze`; the IF stage waits on `if_ready`.
- **Request withdrawn mid-access:** the access still completes and `ready` still pulses.
- **Address bits:** byte address bits [1:0] are ignored. Bits above `SRAM_AW+1` are ignored (wrap-around).
- **Both `mem_r_en` and `mem_w_en` high:** illegal; treated as a write.

## Timing
- **Reset values** (`rst == 0` at an edge):
  - State IDLE, `wait_cnt = 0`, grant = none.
  - `if_ready = mem_ready = 0`; `if_rdata = mem_rdata = 0`.
  - `sram_addr = 0`, `sram_wdata = 0`, `sram_we_n = sram_oe_n = 1`.
  - `freeze` follows its equation.
- **Reset mid-access:** aborts on the same edge; a partial SRAM write is acceptable.
- **Cycle sequence:** request sampled in IDLE at cycle 0 → ACCESS in cycles 1..WAIT_CYCLES → DONE (`ready = 1`) in cycle WAIT_CYCLES+1 → IDLE in cycle WAIT_CYCLES+2.
- **Latency and throughput:** latency is WAIT_CYCLES+1. Sustained throughput is one access per WAIT_CYCLES+2 cycles.
- **Requester handshake:** a requester must deassert, or present a new request, in the cycle after its ready pulse. A request still high in IDLE is treated as new.

## Configuration
- **`SRAM_ARB_RR_EN` defined:**
  - Round-robin on ties: a `last_grant` register (reset: IF) is updated in IDLE on each grant.
  - When both ports are pending, the port not granted last time wins.
  - Bounds IF starvation to one data access.
- **Not defined:** fixed MEM-over-IF priority; no `last_grant` register.

## Structure
- **Package `arm_mem_pkg`:** state enum (IDLE/ACCESS/DONE), grant encoding (GNT_IF/GNT_MEM), default `WAIT_CYCLES`, default `SRAM_AW`.
- **Sub-module `sram_wait_counter`:**
  - Inputs: load, load value, decrement-enable.
  - Output: a zero flag.
  - Instantiated once.

## Test plan
- **Reset:** hold `rst = 0` 3 cycles → all outputs at reset values; `sram_we_n = 1`, `sram_oe_n = 1`.
- **IF read:** `if_req` with `if_addr = 0x10`, SRAM word 4 = 0xE3A00001 → `sram_addr = 4` in cycles 1..4; `if_ready` pulses in cycle 5 with `if_rdata = 0xE3A00001`.
- **MEM write then read:** write `mem_wdata = 0xDEADBEEF` at `mem_addr = 0x400` → `sram_we_n = 0` for exactly 4 cycles at `sram_addr = 0x100`; `freeze = 1` until `mem_ready`. Then a read at 0x400 → `mem_rdata = 0xDEADBEEF`.
- **Simultaneous requests, two tie-rounds:**
  - Without macro: MEM granted both times; IF served only after MEM drops.
  - With `SRAM_ARB_RR_EN`: MEM first, then IF.
- **Reset mid-write:** `rst` low in ACCESS cycle 2 → next edge IDLE, `sram_we_n = 1`, no ready pulse.
- **WAIT_CYCLES = 1:** back-to-back IF requests → ready every 3 cycles.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types for the IF/MEM SRAM arbiter: FSM states, grant encoding,
// default geometry and the latched-request record.
package arm_mem_pkg;

    localparam int DEF_SRAM_AW     = 18;
    localparam int DEF_WAIT_CYCLES = 4;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    typedef struct packed {
        grant_t gnt;
        logic   we;
    } arb_req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester (IF/MEM) and SRAM-side signals of the arbiter.
// The arbiter uses the slave modport; the environment drives through master.
interface sram_arbiter_if #(
    parameter int SRAM_AW = 18
);
    logic               if_req;
    logic [31:0]        if_addr;
    logic [31:0]        if_rdata;
    logic               if_ready;
    logic               mem_r_en;
    logic               mem_w_en;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic               freeze;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_addr, sram_wdata, sram_we_n, sram_oe_n
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Down-counter timing one SRAM access; loads in IDLE, counts down in ACCESS
// and saturates at zero.
module sram_wait_counter
    import arm_mem_pkg::*;
#(
    parameter int W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         zero
);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= load_val;
        end else if (dec_en && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign zero = (wait_cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access.
// Define SRAM_ARB_RR_EN for round-robin on ties; default is MEM-over-IF priority.
module sram_arbiter
    import arm_mem_pkg::*;
#(
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    arb_state_t         state;
    arb_req_t           cur;
    arb_req_t           nxt;
    grant_t             pick;
    logic               mem_pend;
    logic               if_pend;
    logic               cnt_load;
    logic               cnt_zero;
    logic [31:0]        sel_addr;
    logic [SRAM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        if_rdata_q;
    logic [31:0]        mem_rdata_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic               if_ready_q;
    logic               mem_ready_q;
    logic               unused_ok;

    assign mem_pend = bus.mem_r_en | bus.mem_w_en;
    assign if_pend  = bus.if_req;

`ifdef SRAM_ARB_RR_EN
    grant_t last_grant;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        pick = GNT_NONE;
        if (mem_pend && if_pend) pick = (last_grant == GNT_MEM) ? GNT_IF : GNT_MEM;
        else if (mem_pend)       pick = GNT_MEM;
        else if (if_pend)        pick = GNT_IF;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= GNT_IF;
        end else if ((state == IDLE) && (pick != GNT_NONE)) begin
            last_grant <= pick;
        end
    end
`else
    // The data access belongs to the older instruction, so it always wins.
    always_comb begin
        pick = GNT_NONE;
        if (mem_pend)     pick = GNT_MEM;
        else if (if_pend) pick = GNT_IF;
    end
`endif

    // Both enables high is treated as a write.
    assign nxt      = '{gnt: pick, we: (pick == GNT_MEM) & bus.mem_w_en};
    assign sel_addr = (pick == GNT_MEM) ? bus.mem_addr : bus.if_addr;
    assign unused_ok = ^{sel_addr[31:SRAM_AW+2], sel_addr[1:0]};
    assign cnt_load = (state == IDLE) && (pick != GNT_NONE);

    sram_wait_counter #(.W(WAIT_CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES - 1)),
        .dec_en   (state == ACCESS),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cur         <= '{gnt: GNT_NONE, we: 1'b0};
            addr_q      <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    if (pick != GNT_NONE) begin
                        cur     <= nxt;
                        addr_q  <= sel_addr[SRAM_AW+1:2];
                        wdata_q <= bus.mem_wdata;
                        we_n_q  <= ~nxt.we;
                        oe_n_q  <= nxt.we;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (!cur.we) begin
                            if (cur.gnt == GNT_IF) if_rdata_q  <= bus.sram_rdata;
                            else                   mem_rdata_q <= bus.sram_rdata;
                        end
                        we_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        if_ready_q  <= (cur.gnt == GNT_IF);
                        mem_ready_q <= (cur.gnt == GNT_MEM);
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    we_n_q <= 1'b1;
                    oe_n_q <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.freeze     = mem_pend & ~mem_ready_q;

endmodule
